drone_grade_param: RTL and testbench

Parametrised drone-flight game core, the next generation of the fixed-size drone simulator. It provides a configurable grid (width, height), movement tick period, obstacle count and an optional lives mechanism. A slow tick advances the drone one column per step while `controle` steers it vertically. It reports win/loss and drives debug nibbles for the board's 7-segment displays, sitting directly under the board top level.

---
 rtl/drone_pkg.sv | 46 ++++
 rtl/drone_tick_contador.sv | 30 +++
 rtl/drone_grade_param.sv | 134 +++++++++++++
 tb/tb_drone_grade_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/drone_pkg.sv
// Shared constants for the drone game core: state codes, steering codes and the obstacle table.
// Pure definitions; no logic, no latency, no flow control.
package drone_pkg;

  localparam logic [3:0] EST_INICIAL = 4'd0;
  localparam logic [3:0] EST_PREPARA = 4'd1;
  localparam logic [3:0] EST_VOA     = 4'd2;
  localparam logic [3:0] EST_COLISAO = 4'd3;
  localparam logic [3:0] EST_VENCEU  = 4'd4;
  localparam logic [3:0] EST_PERDEU  = 4'd5;

  localparam logic [1:0] CTRL_MANTEM = 2'b00;
  localparam logic [1:0] CTRL_SOBE   = 2'b01;
  localparam logic [1:0] CTRL_DESCE  = 2'b10;

  localparam int N_OBST_MAX = 8;

  function automatic logic [3:0] obst_col(input int idx);
    case (idx)
      0:       return 4'd3;
      1:       return 4'd5;
      2:       return 4'd7;
      3:       return 4'd9;
      4:       return 4'd11;
      5:       return 4'd13;
      6:       return 4'd6;
      7:       return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] obst_lin(input int idx);
    case (idx)
      0:       return 4'd1;
      1:       return 4'd6;
      2:       return 4'd2;
      3:       return 4'd5;
      4:       return 4'd3;
      5:       return 4'd4;
      6:       return 4'd0;
      7:       return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/drone_tick_contador.sv
// Modulo-TICK step counter: counts while conta=1, passo is high on the last count (one cycle).
// Synchronous clear via limpa has priority; no backpressure.
module drone_tick_contador #(
  parameter int TICK = 2000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic passo
);

  localparam int W = $clog2(TICK);
  localparam logic [W-1:0] ULTIMO = W'(TICK - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (limpa) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= (cnt == ULTIMO) ? '0 : cnt + 1'b1;
    end
  end

  assign passo = conta && (cnt == ULTIMO);

endmodule

// File: rtl/drone_grade_param.sv
// Parametrised drone-flight game core; one column per TICK cycles, steering sampled on the step cycle.
// All outputs decoded from registers; optional lives mechanism under `DRONE_VIDAS_EN.
module drone_grade_param
  import drone_pkg::*;
#(
  parameter int LARGURA = 16,
  parameter int ALTURA  = 8,
  parameter int TICK    = 2000,
  parameter int N_OBST  = 4,
  parameter int VIDAS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] controle,
  output logic       venceu,
  output logic       perdeu,
  output logic [3:0] db_posicao_horizontal,
  output logic [3:0] db_posicao_vertical,
  output logic [3:0] db_obstaculos,
  output logic [3:0] db_estado
`ifdef DRONE_VIDAS_EN
  ,output logic [2:0] db_vidas
`endif
);

  localparam logic [3:0] LIN_INI   = 4'(ALTURA / 2);
  localparam logic [3:0] LIN_MAX   = 4'(ALTURA - 1);
  localparam logic [3:0] COL_VENCE = 4'(LARGURA - 1);

  logic [3:0] estado;
  logic [3:0] col;
  logic [3:0] lin;
  logic [3:0] nova_col;
  logic [3:0] nova_lin;
  logic [3:0] n_passados;
  logic       colide;
  logic       passo;
  logic       em_voo;

  assign em_voo = (estado == EST_VOA);

  // Counter is held clear outside VOA, so every entry into VOA starts a full TICK period.
  drone_tick_contador #(.TICK(TICK)) u_tick (
    .clock (clock),
    .reset (reset),
    .limpa (!em_voo),
    .conta (em_voo),
    .passo (passo)
  );

  assign nova_col = col + 4'd1;

  always_comb begin
    nova_lin = lin;
    case (controle)
      CTRL_SOBE:  if (lin != LIN_MAX) nova_lin = lin + 4'd1;
      CTRL_DESCE: if (lin != 4'd0)    nova_lin = lin - 4'd1;
      default:    nova_lin = lin;
    endcase
  end

  always_comb begin
    colide     = 1'b0;
    n_passados = 4'd0;
    for (int i = 0; i < N_OBST_MAX; i++) begin
      if (i < N_OBST) begin
        if ((obst_col(i) == nova_col) && (obst_lin(i) == nova_lin)) colide = 1'b1;
        if (obst_col(i) < col) n_passados = n_passados + 4'd1;
      end
    end
  end

`ifdef DRONE_VIDAS_EN
  logic [2:0] vidas;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= EST_INICIAL;
      col    <= 4'd0;
      lin    <= 4'd0;
`ifdef DRONE_VIDAS_EN
      vidas  <= 3'd0;
`endif
    end else begin
      case (estado)
        EST_INICIAL: if (iniciar) estado <= EST_PREPARA;
        EST_PREPARA: begin
          col    <= 4'd0;
          lin    <= LIN_INI;
`ifdef DRONE_VIDAS_EN
          vidas  <= 3'(VIDAS);
`endif
          estado <= EST_VOA;
        end
        EST_VOA: begin
          if (passo) begin
            col <= nova_col;
            lin <= nova_lin;
            if (colide)                    estado <= EST_COLISAO;
            else if (nova_col == COL_VENCE) estado <= EST_VENCEU;
          end
        end
        EST_COLISAO: begin
`ifdef DRONE_VIDAS_EN
          vidas <= vidas - 3'd1;
          if (vidas > 3'd1) begin
            col    <= 4'd0;
            estado <= EST_VOA;
          end else begin
            estado <= EST_PERDEU;
          end
`else
          estado <= EST_PERDEU;
`endif
        end
        EST_VENCEU, EST_PERDEU: if (iniciar) estado <= EST_PREPARA;
        default: estado <= EST_INICIAL;
      endcase
    end
  end

  assign venceu                = (estado == EST_VENCEU);
  assign perdeu                = (estado == EST_PERDEU);
  assign db_posicao_horizontal = col;
  assign db_posicao_vertical   = lin;
  assign db_obstaculos         = n_passados;
  assign db_estado             = estado;
`ifdef DRONE_VIDAS_EN
  assign db_vidas              = vidas;
`endif

endmodule

// File: tb/tb_drone_grade_param.sv
// Directed bench for drone_grade_param with TICK=4, 16x8 grid, four obstacles.
// Lives scenarios run on a second instance (N_OBST=8) when DRONE_VIDAS_EN is defined.
module tb_drone_grade_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] controle = 2'b00;
  logic       venceu, perdeu;
  logic [3:0] pos_h, pos_v, obst, estado;

  int n_total = 0;
  int n_ok    = 0;

  always #5 clock = ~clock;

`ifdef DRONE_VIDAS_EN
  logic [2:0] vidas_a;
  logic       iniciar_v = 1'b0;
  logic [1:0] controle_v = 2'b00;
  logic       venceu_v, perdeu_v;
  logic [3:0] pos_h_v, pos_v_v, obst_v, estado_v;
  logic [2:0] vidas_v;
`endif

  drone_grade_param #(
    .LARGURA(16), .ALTURA(8), .TICK(4), .N_OBST(4), .VIDAS(3)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .iniciar               (iniciar),
    .controle              (controle),
    .venceu                (venceu),
    .perdeu                (perdeu),
    .db_posicao_horizontal (pos_h),
    .db_posicao_vertical   (pos_v),
    .db_obstaculos         (obst),
    .db_estado             (estado)
`ifdef DRONE_VIDAS_EN
    ,.db_vidas             (vidas_a)
`endif
  );

`ifdef DRONE_VIDAS_EN
  drone_grade_param #(
    .LARGURA(16), .ALTURA(8), .TICK(4), .N_OBST(8), .VIDAS(3)
  ) dut_v (
    .clock                 (clock),
    .reset                 (reset),
    .iniciar               (iniciar_v),
    .controle              (controle_v),
    .venceu                (venceu_v),
    .perdeu                (perdeu_v),
    .db_posicao_horizontal (pos_h_v),
    .db_posicao_vertical   (pos_v_v),
    .db_obstaculos         (obst_v),
    .db_estado             (estado_v),
    .db_vidas              (vidas_v)
  );
`endif

  task automatic verifica(input string tag, input int obs, input int esp);
    n_total++;
    if (obs == esp) n_ok++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // iniciar seen at one edge -> PREPARA; next edge -> VOA with tick counter at 0.
  task automatic inicia();
    iniciar = 1'b1;
    ciclos(1);
    verifica("prepara_estado", estado, 1);
    iniciar = 1'b0;
    ciclos(1);
    verifica("voa_estado", estado, 2);
    verifica("voa_pos", {pos_h, pos_v}, {4'd0, 4'd4});
  endtask

  task automatic reinicia();
    reset = 1'b1;
    #1;
    ciclos(1);
    reset = 1'b0;
    ciclos(1);
  endtask

  initial begin
    // Reset state
    #2;
    verifica("rst_estado", estado, 0);
    verifica("rst_pos", {pos_h, pos_v}, 0);
    verifica("rst_flags", {venceu, perdeu}, 0);
    verifica("rst_obst", obst, 0);
    ciclos(2);
    reset = 1'b0;
    ciclos(2);
    verifica("idle_estado", estado, 0);

    // Clear flight; a steer pulse that is gone before the step cycle must not move the row
    controle = 2'b00;
    inicia();
    controle = 2'b01;
    ciclos(2);
    controle = 2'b00;
    ciclos(2);
    verifica("step1_pos", {pos_h, pos_v}, {4'd1, 4'd4});
    verifica("step1_obst", obst, 0);
    ciclos(52);
    verifica("step14_pos", {pos_h, pos_v}, {4'd14, 4'd4});
    verifica("step14_estado", estado, 2);
    verifica("step14_venceu", venceu, 0);
    ciclos(4);
    verifica("win_venceu", venceu, 1);
    verifica("win_estado", estado, 4);
    verifica("win_pos", {pos_h, pos_v}, {4'd15, 4'd4});
    verifica("win_obst", obst, 4);
    ciclos(6);
    verifica("win_frozen", pos_h, 15);

    // Restart from VENCEU, then iniciar during VOA is ignored
    iniciar = 1'b1;
    ciclos(1);
    verifica("rs_prepara", estado, 1);
    verifica("rs_venceu", venceu, 0);
    iniciar = 1'b0;
    ciclos(1);
    verifica("rs_voa", estado, 2);
    verifica("rs_pos", {pos_h, pos_v}, {4'd0, 4'd4});
    verifica("rs_obst", obst, 0);
    iniciar = 1'b1;
    ciclos(1);
    iniciar = 1'b0;
    verifica("rs_ign_estado", estado, 2);
    ciclos(3);
    verifica("rs_ign_pos", {pos_h, pos_v}, {4'd1, 4'd4});

    // Collision at (3,1)
    reinicia();
    inicia();
    controle = 2'b10;
    ciclos(4);
    verifica("col_p1", {pos_h, pos_v}, {4'd1, 4'd3});
    ciclos(4);
    verifica("col_p2", {pos_h, pos_v}, {4'd2, 4'd2});
    ciclos(4);
    verifica("col_p3", {pos_h, pos_v}, {4'd3, 4'd1});
    verifica("col_estado", estado, 3);
    verifica("col_perdeu0", perdeu, 0);
    ciclos(1);
`ifdef DRONE_VIDAS_EN
    verifica("col_vida_estado", estado, 2);
    verifica("col_vida_pos", {pos_h, pos_v}, {4'd0, 4'd1});
    verifica("col_vidas", vidas_a, 2);
`else
    verifica("lose_estado", estado, 5);
    verifica("lose_perdeu", perdeu, 1);
    ciclos(8);
    verifica("lose_frozen", {pos_h, pos_v}, {4'd3, 4'd1});
`endif

    // Saturation at the top row
    reinicia();
    inicia();
    controle = 2'b01;
    ciclos(12);
    verifica("sat_hi_3", {pos_h, pos_v}, {4'd3, 4'd7});
    ciclos(20);
    verifica("sat_hi_8", {pos_h, pos_v}, {4'd8, 4'd7});
    verifica("sat_hi_estado", estado, 2);

    // Saturation at row 0
    reinicia();
    inicia();
    controle = 2'b00;
    ciclos(12);
    controle = 2'b10;
    ciclos(16);
    verifica("sat_lo_7", {pos_h, pos_v}, {4'd7, 4'd0});
    ciclos(8);
    verifica("sat_lo_9", {pos_h, pos_v}, {4'd9, 4'd0});
    verifica("sat_lo_estado", estado, 2);

    // Asynchronous reset mid-flight takes effect before any clock edge
    ciclos(2);
    reset = 1'b1;
    #1;
    verifica("arst_estado", estado, 0);
    verifica("arst_pos", {pos_h, pos_v}, 0);
    verifica("arst_flags", {venceu, perdeu}, 0);
    ciclos(1);
    reset = 1'b0;
    ciclos(1);

`ifdef DRONE_VIDAS_EN
    iniciar_v = 1'b1;
    ciclos(1);
    iniciar_v = 1'b0;
    ciclos(1);
    verifica("v_vidas_ini", vidas_v, 3);
    controle_v = 2'b10;
    ciclos(12);
    verifica("v_hit1_estado", estado_v, 3);
    ciclos(1);
    verifica("v_hit1_vidas", vidas_v, 2);
    verifica("v_hit1_pos", {pos_h_v, pos_v_v}, {4'd0, 4'd1});
    ciclos(24);
    verifica("v_hit2_pos", {pos_h_v, pos_v_v}, {4'd6, 4'd0});
    verifica("v_hit2_estado", estado_v, 3);
    ciclos(1);
    verifica("v_hit2_vidas", vidas_v, 1);
    verifica("v_hit2_voa", estado_v, 2);
`endif

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
